uart_rx_frame: RTL and testbench

// - Receive stage of the UART link. Recovers 8N1 frames (optional parity) from the serial line rxd.
// - Oversamples rxd at OVERSAMPLE x baud, using the sample_tick enable from the baud-control stage.
// - Presents each byte on a valid/ready holding register, with frame, parity and overrun status.
// - Its output supplies the user data and the reset/command byte that the transmitter path consumes.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx_frame.sv | 158 +++++++++++++++
 tb/tb_uart_rx_frame.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive state encoding, default frame geometry
// and a parity helper used by the receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int DEF_OVERSAMPLE = 12;
  localparam int DEF_DATA_BITS  = 8;

  // Reduction XOR: 1 when the value holds an odd number of ones.
  function automatic logic calc_parity(input logic [31:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle level (1) so a reset never looks like a start bit.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive stage: oversampled 3-sample majority vote, frame FSM and a
// valid/ready holding register with frame, parity and overrun status.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 rxd,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int MID = OVERSAMPLE / 2;
  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_PRE  = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(MID);
  localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);
  localparam logic          PAR_ON   = (PARITY_EN != 0);
  localparam logic          ODD_BIT  = (PARITY_ODD != 0);

  rx_state_t              state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic [BW-1:0]          bit_idx, bit_idx_nx;
  logic [DATA_BITS-1:0]   shreg, shreg_nx;
  logic                   samp_a, samp_a_nx;
  logic                   samp_b, samp_b_nx;
  logic                   par_bit, par_nx;
  logic                   rxd_s;
  logic                   vote;
  logic                   commit;
  logic                   xfer;
  logic                   par_mismatch;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (rxd),
    .dout  (rxd_s)
  );

  // The third sample is the live one; the decision lands on cnt = MID+1.
  assign vote = (samp_a & samp_b) | (samp_a & rxd_s) | (samp_b & rxd_s);
  assign busy = (state != RX_IDLE);
  assign xfer = rx_valid & rx_ready;
  assign par_mismatch = PAR_ON & ((calc_parity(32'(shreg)) ^ par_bit) != ODD_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      samp_a  <= 1'b1;
      samp_b  <= 1'b1;
      par_bit <= 1'b0;
    end else if (sample_tick) begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
      samp_a  <= samp_a_nx;
      samp_b  <= samp_b_nx;
      par_bit <= par_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    samp_a_nx  = (cnt == CNT_PRE) ? rxd_s : samp_a;
    samp_b_nx  = (cnt == CNT_MID) ? rxd_s : samp_b;
    par_nx     = par_bit;
    commit     = 1'b0;
    unique case (state)
      RX_IDLE: begin
        cnt_nx = '0;
        if (!rxd_s) state_nx = RX_START;
      end
      RX_START: begin
        if (cnt == CNT_DEC && vote) begin
          state_nx = RX_IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx   = RX_DATA;
          bit_idx_nx = '0;
        end
      end
      RX_DATA: begin
        if (cnt == CNT_DEC) shreg_nx = {vote, shreg[DATA_BITS-1:1]};
        if (cnt == CNT_LAST) begin
          if (bit_idx == IDX_LAST) begin
            if (PAR_ON) state_nx = RX_PARITY;
            else        state_nx = RX_STOP;
          end else begin
            bit_idx_nx = bit_idx + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (cnt == CNT_DEC)  par_nx   = vote;
        if (cnt == CNT_LAST) state_nx = RX_STOP;
      end
      RX_STOP: begin
        // Leave early so a back-to-back start bit is not missed.
        if (cnt == CNT_DEC) begin
          state_nx = RX_IDLE;
          cnt_nx   = '0;
          commit   = sample_tick;
        end
      end
      default: begin
        state_nx = RX_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // A commit into a full, unaccepted register is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit && !(rx_valid && !rx_ready)) begin
      rx_valid   <= 1'b1;
      rx_data    <= shreg;
      frame_err  <= ~vote;
      parity_err <= par_mismatch;
      if (xfer) overrun <= 1'b0;
    end else begin
      if (commit) overrun <= 1'b1;
      if (xfer) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: table of 8N1 frames plus hand
// sequences for false start, overrun, parity, glitch rejection and reset.
module tb_uart_rx_frame;

  localparam int OS       = 12;
  localparam int TICK_DIV = 16;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sample_tick = 1'b0;
  logic       rxd = 1'b1;
  logic       rxd_p = 1'b1;
  logic       rx_ready = 1'b1;

  logic [7:0] rx_data, p_rx_data;
  logic       rx_valid, frame_err, parity_err, overrun, busy;
  logic       p_rx_valid, p_frame_err, p_parity_err, p_overrun, p_busy;

  int total = 0;
  int bad   = 0;

  uart_rx_frame dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .rxd         (rxd),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  uart_rx_frame #(.PARITY_EN(1), .PARITY_ODD(0)) dut_par (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .rxd         (rxd_p),
    .rx_ready    (rx_ready),
    .rx_data     (p_rx_data),
    .rx_valid    (p_rx_valid),
    .frame_err   (p_frame_err),
    .parity_err  (p_parity_err),
    .overrun     (p_overrun),
    .busy        (p_busy)
  );

  always #10 clk = ~clk;

  // Free-running baud divider, changed on the falling edge so it is stable at posedge.
  int tdiv = 0;
  always @(negedge clk) begin
    tdiv = (tdiv == TICK_DIV - 1) ? 0 : tdiv + 1;
    sample_tick = (tdiv == 0);
  end

  // Capture each delivered frame and count valid cycles, pulses and transfers.
  int         v_cycles = 0, v_pulses = 0, xfers = 0, p_pulses = 0;
  logic       v_prev = 1'b0, p_prev = 1'b0;
  logic [7:0] cap_data = 8'h0, p_cap_data = 8'h0;
  logic       cap_ferr = 1'b0, cap_perr = 1'b0, p_cap_ferr = 1'b0, p_cap_perr = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) v_cycles++;
    if (rx_valid && !v_prev) begin
      v_pulses++;
      cap_data = rx_data;
      cap_ferr = frame_err;
      cap_perr = parity_err;
    end
    if (rx_valid && rx_ready) xfers++;
    v_prev = rx_valid;
    if (p_rx_valid && !p_prev) begin
      p_pulses++;
      p_cap_data = p_rx_data;
      p_cap_ferr = p_frame_err;
      p_cap_perr = p_parity_err;
    end
    p_prev = p_rx_valid;
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: {parity_err, frame_err, data} straight from the frame rules.
  function automatic logic [9:0] ref_frame(input logic [7:0] d, input logic stop_b,
                                           input int par_en, input logic pbit, input int odd);
    logic perr;
    perr = (par_en != 0) && ((($countones(d) + int'(pbit)) % 2) != odd);
    return {perr, ~stop_b, d};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick_gap();
    do @(posedge clk); while (!sample_tick);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input logic sel, input int glitch);
    for (int t = 0; t < OS; t++) begin
      if (sel) rxd_p = (t == glitch) ? ~b : b;
      else     rxd   = (t == glitch) ? ~b : b;
      tick_gap();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic sel,
                            input logic has_par, input logic pbit, input int glitch_bit);
    drive_bit(1'b0, sel, -1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], sel, (i == glitch_bit) ? 7 : -1);
    if (has_par) drive_bit(pbit, sel, -1);
    drive_bit(stop_b, sel, -1);
    drive_bit(1'b1, sel, -1);
  endtask

  task automatic applyStimulus(input vec_t v);
    send_frame(v.data, v.stop, 1'b0, 1'b0, 1'b0, -1);
  endtask

  initial begin
    vec_t       vecs[5];
    vec_t       v;
    logic [9:0] r;
    logic [7:0] d;
    logic       s, pb;
    int         p0, c0, x0;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0};
    for (int i = 3; i < 5; i++) begin
      d = 8'($urandom);
      s = 1'($urandom_range(0, 1));
      r = ref_frame(d, s, 0, 1'b0, 0);
      vecs[i] = '{d, s, r[7:0], r[8], r[9]};
    end

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset rx_valid", rx_valid, 0);
    checkOutput("reset rx_data", rx_data, 0);
    checkOutput("reset frame_err", frame_err, 0);
    checkOutput("reset parity_err", parity_err, 0);
    checkOutput("reset overrun", overrun, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset par busy", p_busy, 0);
    @(negedge clk) rst_n = 1'b1;
    tick_gap();
    tick_gap();

    for (int i = 0; i < 5; i++) begin
      p0 = v_pulses;
      c0 = v_cycles;
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d pulses", i), v_pulses - p0, 1);
      checkOutput($sformatf("vec%0d valid cycles", i), v_cycles - c0, 1);
      checkOutput($sformatf("vec%0d data", i), cap_data, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d frame_err", i), cap_ferr, vecs[i].exp_ferr);
      checkOutput($sformatf("vec%0d parity_err", i), cap_perr, vecs[i].exp_perr);
      checkOutput($sformatf("vec%0d busy after", i), busy, 0);
    end

    $display("[TB] false start");
    p0 = v_pulses;
    for (int t = 0; t < 3; t++) begin
      rxd = 1'b0;
      tick_gap();
    end
    drive_bit(1'b1, 1'b0, -1);
    drive_bit(1'b1, 1'b0, -1);
    checkOutput("false start pulses", v_pulses - p0, 0);
    checkOutput("false start busy", busy, 0);
    v = '{8'h5A, 1'b1, 8'h5A, 1'b0, 1'b0};
    applyStimulus(v);
    checkOutput("after false start pulses", v_pulses - p0, 1);
    checkOutput("after false start data", cap_data, 8'h5A);

    $display("[TB] overrun");
    @(posedge clk);
    #1 rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    checkOutput("ovr first valid", rx_valid, 1);
    checkOutput("ovr first data", rx_data, 8'h11);
    checkOutput("ovr first overrun", overrun, 0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    checkOutput("ovr held valid", rx_valid, 1);
    checkOutput("ovr held data", rx_data, 8'h11);
    checkOutput("ovr flag", overrun, 1);
    x0 = xfers;
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ovr after xfer valid", rx_valid, 0);
    checkOutput("ovr after xfer overrun", overrun, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ovr transfer count", xfers - x0, 1);

    $display("[TB] parity");
    p0 = p_pulses;
    r = ref_frame(8'h07, 1'b1, 1, 1'b0, 0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    checkOutput("par bad pulses", p_pulses - p0, 1);
    checkOutput("par bad data", p_cap_data, 8'h07);
    checkOutput("par bad parity_err", p_cap_perr, 1);
    checkOutput("par bad model", p_cap_perr, r[9]);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1, -1);
    checkOutput("par good parity_err", p_cap_perr, 0);
    checkOutput("par good frame_err", p_cap_ferr, 0);
    d  = 8'($urandom);
    pb = 1'($urandom_range(0, 1));
    r  = ref_frame(d, 1'b1, 1, pb, 0);
    send_frame(d, 1'b1, 1'b1, 1'b1, pb, -1);
    checkOutput("par rand data", p_cap_data, r[7:0]);
    checkOutput("par rand parity_err", p_cap_perr, r[9]);
    checkOutput("par rand pulses", p_pulses - p0, 3);

    $display("[TB] glitch");
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    checkOutput("glitch data", cap_data, 8'h3C);
    checkOutput("glitch frame_err", cap_ferr, 0);

    $display("[TB] reset mid-frame");
    d = 8'hC3;
    drive_bit(1'b0, 1'b0, -1);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0, -1);
    rxd = d[4];
    for (int t = 0; t < 4; t++) tick_gap();
    checkOutput("mid-frame busy", busy, 1);
    @(posedge clk);
    #5 rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset rx_valid", rx_valid, 0);
    checkOutput("async reset rx_data", rx_data, 0);
    checkOutput("async reset frame_err", frame_err, 0);
    checkOutput("async reset overrun", overrun, 0);
    repeat (3) @(posedge clk);
    rxd = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    drive_bit(1'b1, 1'b0, -1);
    drive_bit(1'b1, 1'b0, -1);
    p0 = v_pulses;
    v = '{8'hC3, 1'b1, 8'hC3, 1'b0, 1'b0};
    applyStimulus(v);
    checkOutput("post reset pulses", v_pulses - p0, 1);
    checkOutput("post reset data", cap_data, 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
